debounce_multi: RTL and testbench

//  N-channel switch/button debouncer with configurable stability window and edge-tick mode.

---
 rtl/debounce_multi_pkg.sv | 20 ++
 rtl/debounce_multi_if.sv | 13 +
 rtl/debounce_multi_channel.sv | 94 +++++++++
 rtl/debounce_multi.sv | 46 ++++
 tb/tb_debounce_multi.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/debounce_multi_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
// Holds the tick-mode selector, the per-channel filter state and the counter width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        TICK_RISE = 2'd0,
        TICK_FALL = 2'd1,
        TICK_BOTH = 2'd2
    } tick_mode_e;

    typedef enum logic {
        DB_STABLE = 1'b0,
        DB_CHECK  = 1'b1
    } db_state_e;

    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Switch-side and debounced-side signal bundle of the debouncer.
// The slave modport is the debouncer view; master is the driver/consumer view.
interface debounce_multi_if #(
    parameter int N_CH = 4
);
    logic            en_i;
    logic [N_CH-1:0] sw_i;
    logic [N_CH-1:0] db_level_o;
    logic [N_CH-1:0] db_tick_o;

    modport master (output en_i, output sw_i, input db_level_o, input db_tick_o);
    modport slave  (input en_i, input sw_i, output db_level_o, output db_tick_o);
endinterface

// File: rtl/debounce_multi_channel.sv
// One channel: synchroniser chain, STABLE/CHECK filter and qualification counter.
// Level and tick update SYNC_STAGES+STABLE_CYCLES edges after an input change; no backpressure.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int         STABLE_CYCLES = 20,
    parameter int         SYNC_STAGES   = 2,
    parameter logic       RESET_LEVEL   = 1'b0,
    parameter tick_mode_e TICK_MODE     = TICK_RISE
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic sw_i,
    output logic level_o,
    output logic tick_o
);

    localparam int            CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    db_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   tick_q, tick_d;
    logic                   sync;
    logic                   rise_en, fall_en;

    assign sync    = sync_q[SYNC_STAGES-1];
    assign rise_en = (TICK_MODE == TICK_RISE) || (TICK_MODE == TICK_BOTH);
    assign fall_en = (TICK_MODE == TICK_FALL) || (TICK_MODE == TICK_BOTH);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sw_i};
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        tick_d  = 1'b0;
        // Disabling drops any partial qualification so it restarts from zero.
        if (!en_i) begin
            state_d = DB_STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DB_STABLE: begin
                    if (sync != level_q) begin
                        state_d = DB_CHECK;
                        cnt_d   = CW'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                DB_CHECK: begin
                    if (sync == level_q) begin
                        state_d = DB_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = DB_STABLE;
                        cnt_d   = '0;
                        level_d = ~level_q;
                        tick_d  = level_q ? fall_en : rise_en;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            tick_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            tick_q  <= tick_d;
        end
    end

    assign level_o = level_q;
    assign tick_o  = tick_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel switch debouncer: independent channels, each with its own synchroniser and filter.
// Latency SYNC_STAGES+STABLE_CYCLES edges from a switch change; no backpressure.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int         N_CH          = 4,
    parameter int         STABLE_CYCLES = 20,
    parameter int         SYNC_STAGES   = 2,
    parameter logic       RESET_LEVEL   = 1'b0,
    parameter tick_mode_e TICK_MODE     = TICK_RISE
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    debounce_multi_if.slave bus
);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce_multi: STABLE_CYCLES must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_multi: SYNC_STAGES must be at least 2");
    end

    logic [N_CH-1:0] level;
    logic [N_CH-1:0] tick;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .RESET_LEVEL   (RESET_LEVEL),
            .TICK_MODE     (TICK_MODE)
        ) u_channel (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (bus.en_i),
            .sw_i    (bus.sw_i[ch]),
            .level_o (level[ch]),
            .tick_o  (tick[ch])
        );
    end

    assign bus.db_level_o = level;
    assign bus.db_tick_o  = tick;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: four builds (rise, fall, both, reset-level-1) share clock and enable.
module tb_debounce_multi;
    import debounce_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] sw;
    logic [3:0] sw_rl1;

    int checks = 0;
    int errors = 0;

    debounce_multi_if #(.N_CH(4)) if_rise ();
    debounce_multi_if #(.N_CH(4)) if_fall ();
    debounce_multi_if #(.N_CH(4)) if_both ();
    debounce_multi_if #(.N_CH(4)) if_rl1 ();

    assign if_rise.en_i = en;
    assign if_rise.sw_i = sw;
    assign if_fall.en_i = en;
    assign if_fall.sw_i = sw;
    assign if_both.en_i = en;
    assign if_both.sw_i = sw;
    assign if_rl1.en_i  = en;
    assign if_rl1.sw_i  = sw_rl1;

    debounce_multi #(.N_CH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b0), .TICK_MODE(TICK_RISE))
        dut_rise (.clk_i(clk), .rst_ni(rst_n), .bus(if_rise));
    debounce_multi #(.N_CH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b0), .TICK_MODE(TICK_FALL))
        dut_fall (.clk_i(clk), .rst_ni(rst_n), .bus(if_fall));
    debounce_multi #(.N_CH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b0), .TICK_MODE(TICK_BOTH))
        dut_both (.clk_i(clk), .rst_ni(rst_n), .bus(if_both));
    debounce_multi #(.N_CH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b1), .TICK_MODE(TICK_BOTH))
        dut_rl1 (.clk_i(clk), .rst_ni(rst_n), .bus(if_rl1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sw;
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] t_rise;
        logic [3:0] t_fall;
        logic [3:0] t_both;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance n rising edges and land 1ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single press on ch0: level and tick on the 6th edge after the change.
        vecs[0]  = '{4'h1, 5, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{4'h1, 1, 4'h1, 4'h1, 4'h0, 4'h1};
        vecs[2]  = '{4'h1, 1, 4'h1, 4'h0, 4'h0, 4'h0};
        // ch1 bounce 1,0,1,0 every 2 cycles, then held high.
        vecs[3]  = '{4'h3, 2, 4'h1, 4'h0, 4'h0, 4'h0};
        vecs[4]  = '{4'h1, 2, 4'h1, 4'h0, 4'h0, 4'h0};
        vecs[5]  = '{4'h3, 2, 4'h1, 4'h0, 4'h0, 4'h0};
        vecs[6]  = '{4'h1, 2, 4'h1, 4'h0, 4'h0, 4'h0};
        vecs[7]  = '{4'h3, 5, 4'h1, 4'h0, 4'h0, 4'h0};
        vecs[8]  = '{4'h3, 1, 4'h3, 4'h2, 4'h0, 4'h2};
        vecs[9]  = '{4'h3, 1, 4'h3, 4'h0, 4'h0, 4'h0};
        // ch2 glitch of 3 cycles, then a real press that must count from zero.
        vecs[10] = '{4'h7, 3, 4'h3, 4'h0, 4'h0, 4'h0};
        vecs[11] = '{4'h3, 6, 4'h3, 4'h0, 4'h0, 4'h0};
        vecs[12] = '{4'h7, 5, 4'h3, 4'h0, 4'h0, 4'h0};
        vecs[13] = '{4'h7, 1, 4'h7, 4'h4, 4'h0, 4'h4};
        // ch3 press then release: mode-dependent ticks.
        vecs[14] = '{4'hF, 5, 4'h7, 4'h0, 4'h0, 4'h0};
        vecs[15] = '{4'hF, 1, 4'hF, 4'h8, 4'h0, 4'h8};
        vecs[16] = '{4'h7, 5, 4'hF, 4'h0, 4'h0, 4'h0};
        vecs[17] = '{4'h7, 1, 4'h7, 4'h0, 4'h8, 4'h8};
        vecs[18] = '{4'h7, 1, 4'h7, 4'h0, 4'h0, 4'h0};
        // Three channels released together tick on the same edge.
        vecs[19] = '{4'h0, 6, 4'h0, 4'h0, 4'h7, 4'h7};
        vecs[20] = '{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0};

        rst_n  = 1'b0;
        en     = 1'b1;
        sw     = 4'hF;
        sw_rl1 = 4'h0;
        step(3);
        chk("reset level", {12'h0, if_rise.db_level_o}, 16'h0000);
        chk("reset tick", {4'h0, if_rise.db_tick_o, if_both.db_tick_o, if_rl1.db_tick_o}, 16'h0000);
        chk("reset level rl1", {12'h0, if_rl1.db_level_o}, 16'h000F);

        sw    = 4'h0;
        rst_n = 1'b1;
        step(2);
        chk("post-reset idle", {8'h0, if_rise.db_level_o, if_rise.db_tick_o}, 16'h0000);

        for (int i = 0; i < NV; i++) begin
            sw = vecs[i].sw;
            step(vecs[i].cyc);
            chk($sformatf("vec%0d level", i), {12'h0, if_rise.db_level_o}, {12'h0, vecs[i].lvl});
            chk($sformatf("vec%0d tick_rise", i), {12'h0, if_rise.db_tick_o}, {12'h0, vecs[i].t_rise});
            chk($sformatf("vec%0d tick_fall", i), {12'h0, if_fall.db_tick_o}, {12'h0, vecs[i].t_fall});
            chk($sformatf("vec%0d tick_both", i), {12'h0, if_both.db_tick_o}, {12'h0, vecs[i].t_both});
        end

        // Enable dropped at cnt=2 of a ch0 rise; qualification restarts after it returns.
        sw = 4'h1;
        step(4);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk($sformatf("en low hold %0d", i), {8'h0, if_rise.db_level_o, if_rise.db_tick_o}, 16'h0000);
        end
        en = 1'b1;
        step(3);
        chk("en restart early", {8'h0, if_rise.db_level_o, if_rise.db_tick_o}, 16'h0000);
        step(1);
        chk("en restart update", {8'h0, if_rise.db_level_o, if_rise.db_tick_o}, 16'h0011);
        step(1);
        chk("en restart tick gone", {8'h0, if_rise.db_level_o, if_rise.db_tick_o}, 16'h0010);

        // Reset-level-1 build has followed sw_rl1=0 down to 0 by now.
        chk("rl1 settled low", {12'h0, if_rl1.db_level_o}, 16'h0000);

        // Asynchronous reset while ch0 (fall) and all rl1 channels (rise) sit mid-CHECK.
        sw     = 4'h0;
        sw_rl1 = 4'hF;
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst level", {8'h0, if_rise.db_level_o, if_rise.db_tick_o}, 16'h0000);
        chk("async rst rl1", {8'h0, if_rl1.db_level_o, if_rl1.db_tick_o}, 16'h00F0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk($sformatf("post-abort ticks %0d", i),
                {if_rise.db_tick_o, if_fall.db_tick_o, if_both.db_tick_o, if_rl1.db_tick_o}, 16'h0000);
            chk($sformatf("post-abort levels %0d", i),
                {8'h0, if_rise.db_level_o, if_rl1.db_level_o}, 16'h000F);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
